// File: rtl/pmem_if.sv
// Load/store port between the core LSU (master) and the memory responder (slave).
interface pmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/pmem_responder.sv
// Memory-side endpoint for the core load/store port: one read or masked write per
// transaction, response returned after a programmable latency from an internal word array.
// Optional feature macro: PMEM_RAND_LAT_EN adds 0..3 pseudo-random extra wait cycles
// (8-bit LFSR) on top of LATENCY; undefined gives fixed latency and no LFSR.
module pmem_responder #(
  parameter logic [31:0] ADDR_BASE  = 32'h8000_0000,
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned LATENCY    = 1
) (
  input logic   clk,
  input logic   reset,
  pmem_if.slave bus
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned IDX_W = DEPTH_LOG2;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             wen_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wmask_q;
  logic [31:0]      mem [DEPTH];

  logic             accept_c;
  logic             access_c;
  logic             mem_we_c;
  logic [29:0]      word_off_c;
  logic             in_range_c;
  logic [IDX_W-1:0] idx_c;
  logic [4:0]       shamt_c;
  logic [3:0]       lane_en_c;
  logic [31:0]      lane_data_c;
  logic [CNT_W-1:0] cnt_load_c;

`ifdef PMEM_RAND_LAT_EN
  logic [7:0] lfsr;

  // Free-running Fibonacci LFSR, x^8+x^6+x^5+x^4+1
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= 8'hA5;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  // Counter load covers the LATENCY wait cycles, the random extra, and the access edge
  assign cnt_load_c = CNT_W'(LATENCY) + CNT_W'(lfsr[1:0]) + CNT_W'(1);
`else
  // Counter load covers the LATENCY wait cycles plus the access edge
  assign cnt_load_c = CNT_W'(LATENCY + 1);
`endif

  // Address decode and write-lane alignment of the latched request
  always_comb begin
    accept_c    = (state == IDLE) && bus.req_valid && bus.req_ready;
    access_c    = (state == WAIT) && (cnt == CNT_W'(1));
    word_off_c  = addr_q[31:2] - ADDR_BASE[31:2];
    in_range_c  = (word_off_c >> DEPTH_LOG2) == '0;
    idx_c       = word_off_c[IDX_W-1:0];
    shamt_c     = {addr_q[1:0], 3'b000};
    lane_en_c   = 4'(wmask_q << addr_q[1:0]);
    lane_data_c = wdata_q << shamt_c;
    mem_we_c    = access_c && wen_q && in_range_c && !reset;
  end

  // Capture request fields on the accept edge
  always_ff @(posedge clk) begin
    if (accept_c && !reset) begin
      wen_q   <= bus.req_wen;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      wmask_q <= bus.req_wmask;
    end
  end

  // Byte-lane masked array write; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_en_c[b]) begin
          mem[idx_c][8*b +: 8] <= lane_data_c[8*b +: 8];
        end
      end
    end
  end

  // Transaction FSM with registered handshake and response outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            cnt           <= cnt_load_c;
            bus.req_ready <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (access_c) begin
            cnt            <= '0;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= !in_range_c;
            bus.resp_rdata <= (!wen_q && in_range_c) ? (mem[idx_c] >> shamt_c) : 32'h0;
            state          <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            bus.req_ready  <= 1'b1;
            state          <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pmem_responder.sv
// Bench for pmem_responder: word-array model with per-cycle output checking on a
// LATENCY=1 instance, plus a LATENCY=4 instance for reset-during-transaction cases.
module tb_pmem_responder;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int unsigned DLOG = 12;
  localparam int          LAT1 = 1;
  localparam int          LAT4 = 4;
`ifdef PMEM_RAND_LAT_EN
  localparam int          EXTRA = 3;
`else
  localparam int          EXTRA = 0;
`endif

  logic clk = 1'b0;
  logic rst1;
  logic rst4;
  always #5 clk = ~clk;

  pmem_if p1 ();
  pmem_if p4 ();

  pmem_responder #(.ADDR_BASE(BASE), .DEPTH_LOG2(DLOG), .LATENCY(LAT1)) dut1 (
    .clk(clk), .reset(rst1), .bus(p1));
  pmem_responder #(.ADDR_BASE(BASE), .DEPTH_LOG2(DLOG), .LATENCY(LAT4)) dut4 (
    .clk(clk), .reset(rst4), .bus(p4));

  int total  = 0;
  int passed = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic check_range(input string name, input int val, input int lo, input int hi);
    total++;
    if (val >= lo && val <= hi) passed++;
    else $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, val, lo, hi, $time);
  endtask

  // Reference model: sparse word store, byte-level merge from the request rules
  logic [31:0] mm [int unsigned];

  task automatic model_access(input bit wen, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] m, output logic [31:0] rd, output bit er);
    logic [31:0] offs;
    int unsigned idx;
    int          off;
    logic [31:0] w;
    offs = a - BASE;
    rd   = 32'h0;
    er   = 1'b0;
    if (offs >= (32'd4 << DLOG)) begin
      er = 1'b1;
    end else begin
      idx = offs >> 2;
      off = int'(a[1:0]);
      w   = mm.exists(idx) ? mm[idx] : 32'h0;
      if (wen) begin
        for (int b = 0; b < 4; b++)
          if (b >= off && m[b - off]) w[8*b +: 8] = d[8*(b - off) +: 8];
        mm[idx] = w;
      end else begin
        rd = w >> (8 * off);
      end
    end
  endtask

  // Transaction tracking on dut1
  int          cyc     = 0;
  int          acc_cyc = 0;
  int          lat_c;
  bit          busy    = 1'b0;
  bit          seen    = 1'b0;
  bit          chk_en  = 1'b0;
  logic [31:0] exp_rd  = 32'h0;
  bit          exp_er  = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (rst1) begin
      busy = 1'b0;
    end else if (busy) begin
      if (p1.resp_valid && p1.resp_ready) busy = 1'b0;
    end else if (p1.req_valid && p1.req_ready) begin
      busy    = 1'b1;
      seen    = 1'b0;
      acc_cyc = cyc;
      model_access(p1.req_wen, p1.req_addr, p1.req_wdata, p1.req_wmask, exp_rd, exp_er);
    end
  end

  // Per-cycle comparison of dut1 outputs against the model
  always @(negedge clk) begin
    if (chk_en && !rst1) begin
      if (!busy) begin
        check1("idle_req_ready", p1.req_ready, 1'b1);
        check1("idle_resp_valid", p1.resp_valid, 1'b0);
      end else begin
        lat_c = cyc - acc_cyc;
        check1("busy_req_ready", p1.req_ready, 1'b0);
        if (lat_c < LAT1 + 1) begin
          check1("early_resp_valid", p1.resp_valid, 1'b0);
        end else begin
          if (seen || lat_c >= LAT1 + 1 + EXTRA) check1("resp_valid", p1.resp_valid, 1'b1);
          if (p1.resp_valid) begin
            seen = 1'b1;
            check32("resp_rdata", p1.resp_rdata, exp_rd);
            check1("resp_err", p1.resp_err, exp_er);
          end
        end
      end
    end
  end

  // One dut1 transaction; hold>0 keeps resp_ready low that many cycles with junk requests
  task automatic xact(input bit wen, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] m, input int hold,
                      output logic [31:0] rd, output bit er, output int lat);
    int k;
    @(negedge clk);
    p1.req_valid  = 1'b1;
    p1.req_wen    = wen;
    p1.req_addr   = a;
    p1.req_wdata  = d;
    p1.req_wmask  = m;
    p1.resp_ready = 1'($urandom);
    k = 0;
    while (!p1.req_ready && k < 50) begin @(negedge clk); k++; end
    check1("accept_ready", p1.req_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    p1.req_valid = 1'($urandom);
    p1.req_wen   = 1'($urandom);
    p1.req_addr  = $urandom;
    p1.req_wdata = $urandom;
    p1.req_wmask = 4'($urandom);
    k = 0;
    while (!p1.resp_valid && k < 50) begin @(posedge clk); k++; @(negedge clk); end
    check1("resp_arrives", p1.resp_valid, 1'b1);
    rd  = p1.resp_rdata;
    er  = p1.resp_err;
    lat = k;
    if (hold > 0) begin
      p1.resp_ready = 1'b0;
      p1.req_valid  = 1'b1;
      repeat (hold) @(negedge clk);
    end
    p1.req_valid  = 1'b0;
    p1.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    p1.resp_ready = 1'($urandom);
  endtask

  // One dut4 full-word transaction with immediate response acceptance
  task automatic txn4(input bit wen, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output bit er, output int lat);
    int k;
    @(negedge clk);
    p4.req_valid  = 1'b1;
    p4.req_wen    = wen;
    p4.req_addr   = a;
    p4.req_wdata  = d;
    p4.req_wmask  = 4'hF;
    p4.resp_ready = 1'b1;
    check1("dut4_req_ready", p4.req_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    p4.req_valid = 1'b0;
    k = 0;
    while (!p4.resp_valid && k < 50) begin @(posedge clk); k++; @(negedge clk); end
    check1("dut4_resp_arrives", p4.resp_valid, 1'b1);
    rd  = p4.resp_rdata;
    er  = p4.resp_err;
    lat = k;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [31:0] rd;
  bit          er;
  int          lat;
  int unsigned kidx [17];
  logic [31:0] a;
  int          r;
  int          hold;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst1 = 1'b1;
    rst4 = 1'b1;
    p1.req_valid = 1'b0; p1.req_wen = 1'b0; p1.req_addr = '0; p1.req_wdata = '0;
    p1.req_wmask = '0;   p1.resp_ready = 1'b0;
    p4.req_valid = 1'b0; p4.req_wen = 1'b0; p4.req_addr = '0; p4.req_wdata = '0;
    p4.req_wmask = '0;   p4.resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst1 = 1'b0;
    rst4 = 1'b0;
    @(negedge clk);
    check1("rst_req_ready", p1.req_ready, 1'b1);
    check1("rst_resp_valid", p1.resp_valid, 1'b0);
    check32("rst_resp_rdata", p1.resp_rdata, 32'h0);
    check1("rst_resp_err", p1.resp_err, 1'b0);
    chk_en = 1'b1;

    // Known words: 0..15 and the top word of the array
    for (int i = 0; i < 16; i++) kidx[i] = i;
    kidx[16] = (1 << DLOG) - 1;
    for (int i = 0; i < 17; i++)
      xact(1'b1, BASE + 32'(kidx[i] * 4), {16'hA5A5, 16'(kidx[i])}, 4'hF, 0, rd, er, lat);

    xact(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, rd, er, lat);
    check1("sw_err", er, 1'b0);
    check_range("sw_latency", lat, LAT1 + 1, LAT1 + 1 + EXTRA);
    xact(1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, rd, er, lat);
    check32("lw_rdata", rd, 32'hDEAD_BEEF);
    check1("lw_err", er, 1'b0);
    check_range("lw_latency", lat, LAT1 + 1, LAT1 + 1 + EXTRA);

    xact(1'b1, 32'h8000_0010, 32'h1122_3344, 4'hF, 0, rd, er, lat);
    xact(1'b1, 32'h8000_0013, 32'h0000_00AA, 4'b0001, 0, rd, er, lat);
    xact(1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, rd, er, lat);
    check32("sb_merge", rd, 32'hAA22_3344);
    xact(1'b0, 32'h8000_0013, 32'h0, 4'h0, 0, rd, er, lat);
    check32("lb_shift", rd, 32'h0000_00AA);
    xact(1'b1, 32'h8000_0012, 32'h0000_5566, 4'b0011, 0, rd, er, lat);
    xact(1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, rd, er, lat);
    check32("sh_merge", rd, 32'h5566_3344);

    xact(1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 0, rd, er, lat);
    check1("below_base_err", er, 1'b1);
    check32("below_base_rdata", rd, 32'h0);
    xact(1'b1, 32'h8000_4000, 32'h0BAD_F00D, 4'hF, 0, rd, er, lat);
    check1("above_top_err", er, 1'b1);
    xact(1'b0, 32'h8000_0000, 32'h0, 4'h0, 0, rd, er, lat);
    check32("word0_unchanged", rd, 32'hA5A5_0000);
    xact(1'b0, 32'h8000_3FFC, 32'h0, 4'h0, 0, rd, er, lat);
    check32("top_word_rdata", rd, 32'hA5A5_0FFF);
    check1("top_word_err", er, 1'b0);

    xact(1'b0, 32'h8000_0010, 32'h0, 4'h0, 5, rd, er, lat);
    check32("backpressure_rdata", rd, 32'h5566_3344);

    // Randomized traffic over known words and out-of-range addresses
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r < 8)
        a = BASE + 32'(kidx[$urandom_range(0, 16)] * 4) + 32'($urandom_range(0, 3));
      else if (r == 8)
        a = BASE - 32'(4 * $urandom_range(1, 1000));
      else
        a = BASE + (32'd4 << DLOG) + 32'($urandom_range(0, 10000));
      hold = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0;
      xact(1'($urandom), a, $urandom, 4'($urandom), hold, rd, er, lat);
      check_range("rand_latency", lat, LAT1 + 1, LAT1 + 1 + EXTRA);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // LATENCY=4 instance: write dropped by reset in WAIT, write kept by reset in RESP
    txn4(1'b1, 32'h8000_0020, 32'h1234_5678, rd, er, lat);
    check_range("dut4_latency", lat, LAT4 + 1, LAT4 + 1 + EXTRA);
    @(negedge clk);
    p4.req_valid = 1'b1; p4.req_wen = 1'b1; p4.req_addr = 32'h8000_0020;
    p4.req_wdata = 32'hCAFE_F00D; p4.req_wmask = 4'hF;
    @(posedge clk);
    @(negedge clk);
    p4.req_valid = 1'b0;
    @(negedge clk);
    rst4 = 1'b1;
    @(negedge clk);
    rst4 = 1'b0;
    check1("wait_rst_req_ready", p4.req_ready, 1'b1);
    check1("wait_rst_resp_valid", p4.resp_valid, 1'b0);
    check32("wait_rst_resp_rdata", p4.resp_rdata, 32'h0);
    check1("wait_rst_resp_err", p4.resp_err, 1'b0);
    txn4(1'b0, 32'h8000_0020, 32'h0, rd, er, lat);
    check32("wait_rst_word_kept", rd, 32'h1234_5678);

    @(negedge clk);
    p4.req_valid = 1'b1; p4.req_wen = 1'b1; p4.req_addr = 32'h8000_0024;
    p4.req_wdata = 32'h0000_BEEF; p4.req_wmask = 4'hF; p4.resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    p4.req_valid = 1'b0;
    for (int k = 0; k < 50 && !p4.resp_valid; k++) @(negedge clk);
    check1("resp_rst_valid_seen", p4.resp_valid, 1'b1);
    rst4 = 1'b1;
    @(negedge clk);
    rst4 = 1'b0;
    check1("resp_rst_resp_valid", p4.resp_valid, 1'b0);
    txn4(1'b0, 32'h8000_0024, 32'h0, rd, er, lat);
    check32("resp_rst_commit_kept", rd, 32'h0000_BEEF);

    for (int n = 0; n < 100; n++) begin
      txn4(1'b0, 32'h8000_0020, 32'h0, rd, er, lat);
      check32("dut4_loop_rdata", rd, 32'h1234_5678);
      check_range("dut4_loop_latency", lat, LAT4 + 1, LAT4 + 1 + EXTRA);
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
